// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_mp
//  Description : Multi-read-port register file with hard-wired zero register,
//                optional write-to-read forwarding and a sequential clear
//                engine that walks the file restoring reset contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                NUM_RD  = 2,
    parameter int                BYPASS  = 1,
    parameter int                SP_IDX  = 2,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'('h1001_03FC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     wr_drop_o
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_first_clr = ADDR_W'(1);
    localparam bit                c_bypass_en = (BYPASS != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Value a register holds after reset or after the clear engine visits it.
    function automatic logic [DATA_W-1:0] f_reset_val(input int idx);
        return (idx == SP_IDX) ? SP_INIT : '0;
    endfunction

    logic [DATA_W-1:0] r_regs [DEPTH];
    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_busy;
    logic              r_drop;

    logic              w_addr_nz;
    logic              w_wr_commit;
    logic              w_wr_drop;

    // A write request to a real register either lands (IDLE) or is dropped
    // (CLEAR); index 0 requests are silently ignored in both states.
    assign w_addr_nz   = (wr_addr_i != '0);
    assign w_wr_commit = wr_en_i && w_addr_nz && (r_state == IDLE);
    assign w_wr_drop   = wr_en_i && w_addr_nz && (r_state == CLEAR);

    // Storage, clear sequencer and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= f_reset_val(i);
            end
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= w_wr_drop;
            case (r_state)
                IDLE: begin
                    // A write coinciding with a clear request still lands;
                    // the clear engine overwrites it when it gets there.
                    if (w_wr_commit) begin
                        r_regs[wr_addr_i] <= wr_data_i;
                    end
                    if (clr_req_i) begin
                        r_state <= CLEAR;
                        r_cnt   <= c_first_clr;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Register 0 is never stored-to, so the walk starts at 1.
                    r_regs[r_cnt] <= f_reset_val(int'(r_cnt));
                    if (r_cnt == c_last_idx) begin
                        // Leave before the counter could wrap; it is
                        // reloaded on the next clear request.
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_first_clr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Independent combinational read ports.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_fwd;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
        // Forwarding only ever applies to writes that will actually commit.
        assign w_fwd  = c_bypass_en && w_wr_commit && (w_addr == wr_addr_i);
        assign w_data = (w_addr == '0) ? '0 :
                        w_fwd          ? wr_data_i :
                                         r_regs[w_addr];
        assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
    end

    assign clr_busy_o = r_busy;
    assign wr_drop_o  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_mp
//  Description : Self-checking bench for register_file_mp; runs a forwarding
//                and a non-forwarding instance side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    localparam int          DW = 32;
    localparam int          AW = 5;
    localparam int          NR = 2;
    localparam logic [31:0] SP = 32'h1001_03FC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             wr_en_i;
    logic [AW-1:0]    wr_addr_i;
    logic [DW-1:0]    wr_data_i;
    logic [NR*AW-1:0] rd_addr_i;
    logic             clr_req_i;
    logic [NR*DW-1:0] rd_bp, rd_nb;
    logic             busy_bp, busy_nb, drop_bp, drop_nb;

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_bp),
        .clr_req_i(clr_req_i), .clr_busy_o(busy_bp), .wr_drop_o(drop_bp)
    );

    register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_nb),
        .clr_req_i(clr_req_i), .clr_busy_o(busy_nb), .wr_drop_o(drop_nb)
    );

    // kind: 0 read fwd, 1 read no-fwd, 2/3 busy fwd/no-fwd, 4/5 drop fwd/no-fwd
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a0, a1;
        logic [31:0] e0, e1, e0_nb, e1_nb;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push(input string name, input int kind, input int port, input logic [31:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input string name, input int port, input logic [31:0] e_bp, input logic [31:0] e_nb);
        push(name, 0, port, e_bp);
        push(name, 1, port, e_nb);
    endtask

    task automatic exp_ctl(input string name, input logic busy, input logic drop);
        push({name, "_busy"}, 2, 0, {31'b0, busy});
        push({name, "_busy"}, 3, 0, {31'b0, busy});
        push({name, "_drop"}, 4, 0, {31'b0, drop});
        push({name, "_drop"}, 5, 0, {31'b0, drop});
    endtask

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = rd_bp[e.port*DW +: DW];
                1:       act = rd_nb[e.port*DW +: DW];
                2:       act = {31'b0, busy_bp};
                3:       act = {31'b0, busy_nb};
                4:       act = {31'b0, drop_bp};
                5:       act = {31'b0, drop_nb};
                default: act = 'x;
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_errors++;
                $display("FAIL %s (kind %0d port %0d): got %h expected %h",
                         e.name, e.kind, e.port, act, e.exp);
            end
        end
    endtask

    task automatic idle_in();
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; clr_req_i = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle_in();
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        next_cycle();
        idle_in();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 5'd0,  32'h0,         5'd2,  5'd5,  SP,            32'h0,         SP,            32'h0};
        vecs[1] = '{1'b1, 5'd7,  32'hDEAD_BEEF, 5'd2,  5'd7,  SP,            32'hDEAD_BEEF, SP,            32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 5'd0,  32'h1234,      5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd7,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 5'd2,  32'h5555_0000, 5'd2,  5'd3,  32'h5555_0000, 32'h0,         SP,            32'h0};
        vecs[6] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd2,  32'hFFFF_FFFF, 32'h5555_0000, 32'h0,         32'h5555_0000};
        vecs[7] = '{1'b0, 5'd9,  32'h1234_5678, 5'd9,  5'd31, 32'h0,         32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF};

        // Reset state
        reset = 1'b0;
        idle_in();
        set_rd(5'd2, 5'd5);
        next_cycle();
        next_cycle();
        exp_ctl("rst", 1'b0, 1'b0);
        exp_rd("rst_p0", 0, SP, SP);
        exp_rd("rst_p1", 1, 32'h0, 32'h0);
        @(negedge clk);
        check_all();
        next_cycle();
        reset = 1'b1;

        // Table-driven single-cycle vectors
        for (int v = 0; v < 8; v++) begin
            idle_in();
            wr_en_i = vecs[v].wr_en; wr_addr_i = vecs[v].wa; wr_data_i = vecs[v].wd;
            set_rd(vecs[v].a0, vecs[v].a1);
            exp_rd($sformatf("vec%0d_p0", v), 0, vecs[v].e0, vecs[v].e0_nb);
            exp_rd($sformatf("vec%0d_p1", v), 1, vecs[v].e1, vecs[v].e1_nb);
            exp_ctl($sformatf("vec%0d", v), 1'b0, 1'b0);
            @(negedge clk);
            check_all();
            next_cycle();
        end

        // Fill every register with its own index
        for (int i = 1; i < 32; i++) write(5'(i), 32'(i));

        // Full clear with a coincident write, a dropped write and a
        // redundant clear request part-way through
        for (int c = 0; c <= 40; c++) begin
            idle_in();
            set_rd(5'd0, 5'd0);
            if (c == 0) begin
                clr_req_i = 1'b1;
                wr_en_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = 32'h0000_CAFE;
            end
            if (c == 3) begin
                set_rd(5'd5, 5'd1);
                exp_rd("clr_coincident_wr", 0, 32'h0000_CAFE, 32'h0000_CAFE);
                exp_rd("clr_idx1_done", 1, 32'h0, 32'h0);
            end
            if (c == 5) begin
                wr_en_i = 1'b1; wr_addr_i = 5'd20; wr_data_i = 32'hAAAA_5555;
                set_rd(5'd20, 5'd1);
                exp_rd("clr_no_fwd", 0, 32'd20, 32'd20);
                exp_rd("clr_idx1", 1, 32'h0, 32'h0);
            end
            if (c == 10) clr_req_i = 1'b1;
            if (c == 21) begin
                set_rd(5'd20, 5'd25);
                exp_rd("clr_idx20_done", 0, 32'h0, 32'h0);
                exp_rd("clr_idx25_old", 1, 32'd25, 32'd25);
            end
            exp_ctl($sformatf("clr_c%0d", c), (c >= 1 && c <= 31), (c == 6));
            @(negedge clk);
            check_all();
            next_cycle();
        end

        // Every register back to its reset value
        idle_in();
        for (int k = 0; k < 16; k++) begin
            set_rd(5'(2*k), 5'(2*k+1));
            exp_rd($sformatf("post_clr_%0d", 2*k), 0, (2*k == 2) ? SP : 32'h0, (2*k == 2) ? SP : 32'h0);
            exp_rd($sformatf("post_clr_%0d", 2*k+1), 1, 32'h0, 32'h0);
            @(negedge clk);
            check_all();
            next_cycle();
        end

        // Reset ten cycles into a clear
        write(5'd25, 32'h77);
        write(5'd2, 32'h1);
        clr_req_i = 1'b1;
        next_cycle();
        idle_in();
        for (int c = 1; c < 10; c++) next_cycle();
        exp_ctl("pre_abort", 1'b1, 1'b0);
        check_all();
        #2;
        reset = 1'b0;
        #1;
        set_rd(5'd25, 5'd2);
        #1;
        exp_ctl("abort", 1'b0, 1'b0);
        exp_rd("abort_idx25", 0, 32'h0, 32'h0);
        exp_rd("abort_idx2", 1, SP, SP);
        check_all();
        next_cycle();
        exp_ctl("abort_hold", 1'b0, 1'b0);
        @(negedge clk);
        check_all();
        next_cycle();
        reset = 1'b1;
        write(5'd9, 32'h0000_00FF);
        set_rd(5'd9, 5'd9);
        exp_rd("after_rst_p0", 0, 32'h0000_00FF, 32'h0000_00FF);
        exp_rd("after_rst_p1", 1, 32'h0000_00FF, 32'h0000_00FF);
        exp_ctl("after_rst", 1'b0, 1'b0);
        @(negedge clk);
        check_all();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-005 Parameter SP_IDX, default 2: index of the register with a non-zero reset value.
REQ-006 Parameter SP_INIT, default 'h1001_03FC: reset/clear value of register SP_IDX.
REQ-007 clk  input  1  clock; all state updates on the rising edge; single clock domain.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 wr_en_i  input  1  write request for the current cycle.
REQ-010 wr_addr_i  input  ADDR_W  write register index.
REQ-011 wr_data_i  input  DATA_W  write data.
REQ-012 rd_addr_i  input  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-013 rd_data_o  output  NUM_RD*DATA_W  read data; port k drives bits [k*DATA_W +: DATA_W].
REQ-014 clr_req_i  input  1  request a sequential clear of the whole file.
REQ-015 clr_busy_o  output  1  high while a clear sequence is in progress.
REQ-016 wr_drop_o  output  1  one-cycle pulse: a write was discarded.

Function
REQ-017 Register 0 SHALL read 0 on every port at all times; writes to index 0 are ignored, without a wr_drop_o pulse.
REQ-018 Reads SHALL be combinational: each port is independent, and any number of ports may address the same register.
REQ-019 A write SHALL be committed on the rising edge when all of these hold: wr_en_i=1, wr_addr_i!=0 and state=IDLE.
REQ-020 With BYPASS=1, in IDLE with wr_en_i=1 and rd_addr==wr_addr_i!=0, that port SHALL output wr_data_i in the same cycle; otherwise the port shows stored data.
REQ-021 With BYPASS=0, a written value SHALL become visible on the cycle after the commit edge.
REQ-022 The FSM SHALL have two states, IDLE and CLEAR.
REQ-023 IDLE->CLEAR SHALL occur on an edge with clr_req_i=1; on that edge the clear counter loads 1.
REQ-024 In CLEAR, each edge SHALL load register[counter] with its reset value (SP_INIT for SP_IDX, 0 otherwise), then increment the counter.
REQ-025 The edge that clears index DEPTH-1 SHALL return the FSM to IDLE; a clear therefore occupies exactly DEPTH-1 cycles in CLEAR.
REQ-026 The counter SHALL be ADDR_W bits wide and never wraps; CLEAR is left before overflow.
REQ-027 clr_busy_o SHALL be registered and equal 1 exactly when state=CLEAR.
REQ-028 In CLEAR, a write with wr_en_i=1 and wr_addr_i!=0 SHALL be discarded and produce wr_drop_o=1 on the following cycle; bypass is suppressed for it.
REQ-029 clr_req_i asserted while in CLEAR SHALL be ignored; the clear does not restart.
REQ-030 A write and clr_req_i in the same IDLE cycle: the write SHALL commit, then the clear SHALL overwrite it later.
REQ-031 Reads during CLEAR SHALL return the current array contents: cleared entries show reset values, uncleared entries show old data.
REQ-032 Arithmetic SHALL be width-exact; there is no sign extension or truncation of data.

Reset
REQ-033 Asserting reset (reset=0) SHALL immediately, independent of clk, set:
- all registers to 0, except SP_IDX = SP_INIT;
- state = IDLE and counter = 0;
- clr_busy_o = 0 and wr_drop_o = 0.
REQ-034 Reset asserted in the middle of a clear SHALL abort the clear; after release the FSM is in IDLE and the file holds full reset contents.
REQ-035 After reset release, the first rising edge SHALL accept writes normally.

Verification
REQ-036 Reset, then read index 2 and index 5 on ports 0 and 1 -> 0x1001_03FC and 0x0000_0000.
REQ-037 Write 0xDEAD_BEEF to index 7, with port 1 reading index 7 in the same cycle:
- BYPASS=1 -> 0xDEAD_BEEF in that cycle;
- BYPASS=0 -> old value 0 in that cycle, then 0xDEAD_BEEF on the next cycle.
REQ-038 Write 0x1234 to index 0 -> every port reading index 0 returns 0; wr_drop_o stays 0.
REQ-039 Fill indices 1..31 with the value of their index, then pulse clr_req_i:
- clr_busy_o is high for 31 cycles;
- after completion index 2 = 0x1001_03FC and all other indices = 0.
REQ-040 During CLEAR, write 0xAAAA_5555 to index 20 -> wr_drop_o pulses once and index 20 ends at 0; a clr_req_i issued mid-clear does not extend busy beyond 31 cycles.
REQ-041 Assert reset 10 cycles into a clear -> clr_busy_o falls immediately; after release, write and read back index 9 = 0x0000_00FF.
